ravens_spike_to_dvs_event: RTL and testbench

Decoder for the return path from the RAVENS neuromorphic core. It accepts RAVENS output spike packets over a valid/ready handshake and rebuilds each one as a DVS-format event so downstream logic can treat network output like camera input. The flat 8-bit neuron index (`{core_address, neuron_index}`) is mapped back to pixel coordinates with an iterative divider. Packets that cannot be decoded are dropped and counted.

---
 rtl/dvs_ravens_pkg.sv | 40 ++++
 rtl/ravens_spike_to_dvs_event_if.sv | 31 +++
 rtl/ravens_idx_divider.sv | 62 ++++++
 rtl/ravens_spike_to_dvs_event.sv | 118 +++++++++++
 tb/tb_ravens_spike_to_dvs_event.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/dvs_ravens_pkg.sv
// Shared types and constants for the RAVENS-output to DVS-event return path.
// Event layout is {x, y, polarity, timestamp} with x in the MSBs.
package dvs_ravens_pkg;

    localparam int unsigned EVENT_BITS      = 32;
    localparam int unsigned DVS_X_ADDR_BITS = 4;
    localparam int unsigned DVS_Y_ADDR_BITS = 3;
    localparam int unsigned DVS_WIDTH_PXLS  = 16;
    localparam int unsigned RAVENS_PKT_BITS = 32;
    localparam int unsigned DVS_TS_BITS     = EVENT_BITS - DVS_X_ADDR_BITS - DVS_Y_ADDR_BITS - 1;

    // One spare bit over the 8-bit index so 255 never wraps during subtraction.
    localparam int unsigned DIV_BITS = 9;

    localparam logic [2:0] RAVENS_HDR_SPIKE = 3'b000;

    typedef struct packed {
        logic [2:0]  header;
        logic [15:0] tstamp;
        logic [3:0]  core;
        logic [3:0]  neuron;
        logic [4:0]  synapse;
    } ravens_pkt_t;

    typedef enum logic [1:0] {
        StIdle,
        StDiv,
        StOut
    } dvs_state_e;

    // Timestamp is zero-extended or truncated to DVS_TS_BITS by the size cast.
    function automatic logic [EVENT_BITS-1:0] make_event(
        input logic [DVS_X_ADDR_BITS-1:0] x,
        input logic [DVS_Y_ADDR_BITS-1:0] y,
        input logic [15:0]                ts
    );
        return {x, y, 1'b1, DVS_TS_BITS'(ts)};
    endfunction

endpackage

// File: rtl/ravens_spike_to_dvs_event_if.sv
// Packet-in / event-out handshake bundle for ravens_spike_to_dvs_event.
// The slave modport is the decoder's view; master is the driver/sink side.
interface ravens_spike_to_dvs_event_if;
    import dvs_ravens_pkg::*;

    logic                       pkt_valid;
    logic                       pkt_ready;
    logic [RAVENS_PKT_BITS-1:0] ravens_pkt;
    logic                       evt_valid;
    logic                       evt_ready;
    logic [EVENT_BITS-1:0]      dvs_event;

    modport master (
        output pkt_valid,
        output ravens_pkt,
        output evt_ready,
        input  pkt_ready,
        input  evt_valid,
        input  dvs_event
    );

    modport slave (
        input  pkt_valid,
        input  ravens_pkt,
        input  evt_ready,
        output pkt_ready,
        output evt_valid,
        output dvs_event
    );

endinterface

// File: rtl/ravens_idx_divider.sv
// Repeated-subtraction divider: flat neuron index / DVS_WIDTH_PXLS.
// One subtraction per cycle; flags overflow when the quotient would exceed the Y range.
module ravens_idx_divider
    import dvs_ravens_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [7:0]          dividend_i,
    output logic [DIV_BITS-1:0] quotient_o,
    output logic [DIV_BITS-1:0] remainder_o,
    output logic                done_o,
    output logic                overflow_o
);

    localparam logic [DIV_BITS-1:0] Divisor = DIV_BITS'(DVS_WIDTH_PXLS);
    localparam logic [DIV_BITS-1:0] QuotMax = DIV_BITS'((1 << DVS_Y_ADDR_BITS) - 1);

    logic                busy_q, busy_d;
    logic [DIV_BITS-1:0] rem_q, rem_d;
    logic [DIV_BITS-1:0] quot_q, quot_d;
    logic                rem_ge;

    always_comb begin
        rem_ge     = (rem_q >= Divisor);
        done_o     = busy_q && !rem_ge;
        overflow_o = busy_q && rem_ge && (quot_q == QuotMax);

        busy_d = busy_q;
        rem_d  = rem_q;
        quot_d = quot_q;

        if (start_i) begin
            busy_d = 1'b1;
            rem_d  = {1'b0, dividend_i};
            quot_d = '0;
        end else if (busy_q) begin
            if (done_o || overflow_o) begin
                busy_d = 1'b0;
            end else begin
                rem_d  = rem_q - Divisor;
                quot_d = quot_q + DIV_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= 1'b0;
            rem_q  <= '0;
            quot_q <= '0;
        end else begin
            busy_q <= busy_d;
            rem_q  <= rem_d;
            quot_q <= quot_d;
        end
    end

    assign quotient_o  = quot_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/ravens_spike_to_dvs_event.sv
// Rebuilds RAVENS output spike packets as DVS events; undecodable packets are dropped.
// Define DVS_RAVENS_DROP_CNT_EN to build the saturating drop counter (else drop_count = 0).
module ravens_spike_to_dvs_event
    import dvs_ravens_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst_n,
    ravens_spike_to_dvs_event_if.slave       bus,
    output logic [15:0]                      drop_count
);

    dvs_state_e            state_q, state_d;
    logic                  pkt_ready_q, pkt_ready_d;
    logic [EVENT_BITS-1:0] evt_q, evt_d;
    logic [15:0]           ts_q, ts_d;

    ravens_pkt_t           pkt;
    logic                  accept;
    logic                  is_spike;
    logic                  div_start;
    logic                  drop;
    logic [DIV_BITS-1:0]   div_quot;
    logic [DIV_BITS-1:0]   div_rem;
    logic                  div_done;
    logic                  div_ovf;

    assign pkt       = bus.ravens_pkt;
    assign accept    = (state_q == StIdle) && bus.pkt_valid && pkt_ready_q;
    assign is_spike  = (pkt.header == RAVENS_HDR_SPIKE);
    assign div_start = accept && is_spike;
    assign drop      = (accept && !is_spike) || ((state_q == StDiv) && div_ovf);

    ravens_idx_divider u_divider (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (div_start),
        .dividend_i  ({pkt.core, pkt.neuron}),
        .quotient_o  (div_quot),
        .remainder_o (div_rem),
        .done_o      (div_done),
        .overflow_o  (div_ovf)
    );

    always_comb begin
        state_d = state_q;
        evt_d   = evt_q;
        ts_d    = ts_q;

        unique case (state_q)
            StIdle: begin
                if (div_start) begin
                    state_d = StDiv;
                    ts_d    = pkt.tstamp;
                end
            end
            StDiv: begin
                if (div_ovf) begin
                    state_d = StIdle;
                end else if (div_done) begin
                    state_d = StOut;
                    evt_d   = make_event(div_rem[DVS_X_ADDR_BITS-1:0],
                                         div_quot[DVS_Y_ADDR_BITS-1:0], ts_q);
                end
            end
            StOut: begin
                if (bus.evt_ready) begin
                    state_d = StIdle;
                    evt_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        pkt_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            pkt_ready_q <= 1'b0;
            evt_q       <= '0;
            ts_q        <= '0;
        end else begin
            state_q     <= state_d;
            pkt_ready_q <= pkt_ready_d;
            evt_q       <= evt_d;
            ts_q        <= ts_d;
        end
    end

    assign bus.pkt_ready = pkt_ready_q;
    assign bus.evt_valid = (state_q == StOut);
    assign bus.dvs_event = evt_q;

`ifdef DVS_RAVENS_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_count = drop_cnt_q;
`else
    logic drop_unused;
    assign drop_unused = drop;
    assign drop_count  = '0;
`endif

    // Synapse field and the divider's spare high bits carry no event information.
    logic fields_unused;
    assign fields_unused = ^{pkt.synapse, div_rem[DIV_BITS-1:DVS_X_ADDR_BITS],
                             div_quot[DIV_BITS-1:DVS_Y_ADDR_BITS]};

endmodule

// File: tb/tb_ravens_spike_to_dvs_event.sv
// Directed bench for ravens_spike_to_dvs_event (row width 16, X 4 bits, Y 3 bits, TS 24 bits).
// Latency is counted with the accept edge as edge 1.
module tb_ravens_spike_to_dvs_event;

`ifdef DVS_RAVENS_DROP_CNT_EN
    localparam int CntEn = 1;
`else
    localparam int CntEn = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] drop_count;
    int          tests = 0;
    int          errors = 0;

    ravens_spike_to_dvs_event_if bus ();

    ravens_spike_to_dvs_event dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_pkt(input logic [2:0] hdr, input logic [15:0] ts,
                                           input logic [3:0] core, input logic [3:0] nrn,
                                           input logic [4:0] syn);
        return {hdr, ts, core, nrn, syn};
    endfunction

    // Leaves time at #1 after the accept edge.
    task automatic send(input logic [31:0] p);
        int n = 0;
        bus.ravens_pkt = p;
        bus.pkt_valid  = 1'b1;
        while (!bus.pkt_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("pkt_ready_before_accept", 32'(bus.pkt_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.pkt_valid  = 1'b0;
        bus.ravens_pkt = '0;
    endtask

    task automatic wait_evt(output int lat);
        lat = 1;
        while (!bus.evt_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume();
        bus.evt_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.evt_ready = 1'b0;
        check("evt_valid_after_consume", 32'(bus.evt_valid), 32'd0);
        check("dvs_event_cleared", bus.dvs_event, 32'd0);
        check("pkt_ready_after_consume", 32'(bus.pkt_ready), 32'd1);
    endtask

    task automatic expect_drop(input logic [31:0] p, input int drops);
        int seen = 0;
        send(p);
        for (int i = 0; i < 12; i++) begin
            if (bus.evt_valid) seen++;
            @(posedge clk);
            #1;
        end
        check("dropped_no_event", 32'(seen), 32'd0);
        check("dropped_pkt_ready", 32'(bus.pkt_ready), 32'd1);
        check("dropped_count", 32'(drop_count), 32'(drops * CntEn));
    endtask

    initial begin
        int lat;
        bus.pkt_valid  = 1'b0;
        bus.ravens_pkt = '0;
        bus.evt_ready  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_pkt_ready", 32'(bus.pkt_ready), 32'd0);
        check("rst_evt_valid", 32'(bus.evt_valid), 32'd0);
        check("rst_dvs_event", bus.dvs_event, 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_pkt_ready", 32'(bus.pkt_ready), 32'd1);

        // idx 37 -> x=5, y=2
        send(mk_pkt(3'b000, 16'h1234, 4'd2, 4'd5, 5'd17));
        check("idx37_busy", 32'(bus.pkt_ready), 32'd0);
        wait_evt(lat);
        check("idx37_latency", 32'(lat), 32'd4);
        check("idx37_event", bus.dvs_event, 32'h5500_1234);
        consume();

        // idx 0 -> x=0, y=0
        send(mk_pkt(3'b000, 16'hBEEF, 4'd0, 4'd0, 5'h1F));
        wait_evt(lat);
        check("idx0_latency", 32'(lat), 32'd2);
        check("idx0_event", bus.dvs_event, 32'h0100_BEEF);
        check("idx0_drop_count", 32'(drop_count), 32'd0);
        consume();

        // Non-spike header
        send(mk_pkt(3'b010, 16'hFFFF, 4'd3, 4'd3, 5'd3));
        check("hdr_no_evt", 32'(bus.evt_valid), 32'd0);
        check("hdr_pkt_ready", 32'(bus.pkt_ready), 32'd1);
        check("hdr_drop_count", 32'(drop_count), 32'(CntEn));

        // idx 200 -> q=12 exceeds Y range of 7
        expect_drop(mk_pkt(3'b000, 16'h0007, 4'd12, 4'd8, 5'd0), 2);

        // idx 127 -> q=7, rem=15: largest decodable index
        send(mk_pkt(3'b000, 16'h0001, 4'd7, 4'd15, 5'd0));
        wait_evt(lat);
        check("idx127_latency", 32'(lat), 32'd9);
        check("idx127_event", bus.dvs_event, 32'hFF00_0001);
        consume();

        // idx 128 -> q=8, first overflowing index
        expect_drop(mk_pkt(3'b000, 16'h0002, 4'd8, 4'd0, 5'd0), 3);

        // Backpressure: idx 19 -> x=3, y=1
        send(mk_pkt(3'b000, 16'hA5A5, 4'd1, 4'd3, 5'd9));
        wait_evt(lat);
        check("bp_latency", 32'(lat), 32'd3);
        for (int i = 0; i < 5; i++) begin
            check("bp_event_stable", bus.dvs_event, 32'h3300_A5A5);
            check("bp_pkt_ready_low", 32'(bus.pkt_ready), 32'd0);
            check("bp_evt_valid_held", 32'(bus.evt_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        consume();

        // Reset in second DIV cycle of idx 100
        send(mk_pkt(3'b000, 16'h0055, 4'd6, 4'd4, 5'd0));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_pkt_ready", 32'(bus.pkt_ready), 32'd0);
        check("midrst_evt_valid", 32'(bus.evt_valid), 32'd0);
        check("midrst_dvs_event", bus.dvs_event, 32'd0);
        check("midrst_drop_count", 32'(drop_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_pkt_ready", 32'(bus.pkt_ready), 32'd1);
        send(mk_pkt(3'b000, 16'h0042, 4'd2, 4'd5, 5'd0));
        wait_evt(lat);
        check("postrst_latency", 32'(lat), 32'd4);
        check("postrst_event", bus.dvs_event, 32'h5500_0042);
        check("postrst_drop_count", 32'(drop_count), 32'd0);
        consume();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
